// File: rtl/mips_mul_div_unit.sv
// mips_mul_div_unit
//   Multi-cycle multiply/divide unit. It owns the architectural HI/LO registers
//   and answers the EX-stage start/busy handshake.
//   - MULT/MULTU: the result lands after MUL_CYCLES busy cycles.
//   - DIV/DIVU: a radix-2 restoring divider that produces one quotient bit per
//     cycle over DIV_CYCLES busy cycles.
//   - MFHI/MFLO: read combinationally through dataRead.
//   - MTHI/MTLO: write in a single cycle; busy stays low.
//
// Ports:
//   clock, reset  clock and synchronous active-high reset
//   operand1      rs value: multiplicand, dividend, or MTHI/MTLO source
//   operand2      rt value: multiplier or divisor
//   operation     0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//                 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO (9-15 act as NONE)
//   start         request; sampled only while busy is low
//   busy          registered; high while a mul/div is in flight
//   dataRead      HI for MFHI, LO for MFLO, otherwise 0
//   hi, lo        current HI/LO values
//
// State   | meaning
// IDLE    | waiting for start; MTHI/MTLO are handled here
// MUL     | multiply in flight, counting down MUL_CYCLES
// DIV     | divide in flight, one quotient bit per cycle
module mips_mul_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic [3:0]  operation,
    input  logic        start,
    output logic        busy,
    output logic [31:0] dataRead,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t      state, state_next;
    logic [5:0]  cnt;
    logic [31:0] op_a;        // multiplicand, or the dividend magnitude as it shifts into the quotient
    logic [31:0] op_b;        // multiplier, or the divisor magnitude
    logic [31:0] rem;
    logic        mul_signed;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;

    logic        last;
    logic [63:0] a_ext, b_ext, product;
    logic [32:0] rem_shift, diff;
    logic [31:0] new_quo, new_rem;
    logic [31:0] q_fix, r_fix;
    logic        a_neg, b_neg;
    logic [31:0] abs1, abs2;

    // The terminal count is 1, so the counter value at load equals the number of busy cycles.
    assign last = (cnt == 6'd1);

    // Signedness comes from the latched flag, so the sign extension can be done at full width.
    assign a_ext   = mul_signed ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
    assign b_ext   = mul_signed ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
    assign product = a_ext * b_ext;

    // One restoring step: shift the next dividend bit into the remainder, then try the subtract.
    assign rem_shift = {rem, op_a[31]};
    assign diff      = rem_shift - {1'b0, op_b};
    assign new_quo   = {op_a[30:0], ~diff[32]};
    assign new_rem   = diff[32] ? rem_shift[31:0] : diff[31:0];
    assign q_fix     = neg_q ? -new_quo : new_quo;
    assign r_fix     = neg_r ? -new_rem : new_rem;

    assign a_neg = (operation == OP_DIV) && operand1[31];
    assign b_neg = (operation == OP_DIV) && operand2[31];
    assign abs1  = a_neg ? -operand1 : operand1;
    assign abs2  = b_neg ? -operand2 : operand2;

    always_comb begin
        dataRead = 32'd0;
        if (operation == OP_MFHI)
            dataRead = hi;
        else if (operation == OP_MFLO)
            dataRead = lo;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (operation == OP_MULT || operation == OP_MULTU)
                        state_next = MUL;
                    else if (operation == OP_DIV || operation == OP_DIVU)
                        state_next = DIV;
                end
            end
            MUL:     if (last) state_next = IDLE;
            DIV:     if (last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            cnt        <= 6'd0;
            hi         <= 32'd0;
            lo         <= 32'd0;
            op_a       <= 32'd0;
            op_b       <= 32'd0;
            rem        <= 32'd0;
            mul_signed <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div_zero   <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        case (operation)
                            OP_MULT, OP_MULTU: begin
                                op_a       <= operand1;
                                op_b       <= operand2;
                                mul_signed <= (operation == OP_MULT);
                                cnt        <= 6'(MUL_CYCLES);
                            end
                            OP_DIV, OP_DIVU: begin
                                op_a     <= abs1;
                                op_b     <= abs2;
                                rem      <= 32'd0;
                                neg_q    <= a_neg ^ b_neg;
                                neg_r    <= a_neg;
                                div_zero <= (operand2 == 32'd0);
                                cnt      <= 6'(DIV_CYCLES);
                            end
                            OP_MTHI: hi <= operand1;
                            OP_MTLO: lo <= operand1;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    cnt <= cnt - 6'd1;
                    if (last) begin
                        hi <= product[63:32];
                        lo <= product[31:0];
                    end
                end
                DIV: begin
                    cnt  <= cnt - 6'd1;
                    op_a <= new_quo;
                    rem  <= new_rem;
                    // A zero divisor still runs the full latency but leaves HI/LO untouched.
                    if (last && !div_zero) begin
                        lo <= q_fix;
                        hi <= r_fix;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mips_mul_div_unit.md
Name: mips_mul_div_unit

Overview:
Multi-cycle multiply/divide responder to the EX-stage start/busy protocol. Owns the architectural HI/LO registers. Executes MULT/MULTU iteratively and DIV/DIVU as a radix-2 restoring divider. Serves MFHI/MFLO reads combinationally and MTHI/MTLO writes in a single cycle. EX gates start with its own stall, so busy must never depend combinationally on start.

Parameters:
MUL_CYCLES, 5, busy cycles for MULT/MULTU (minimum 1)
DIV_CYCLES, 32, busy cycles for DIV/DIVU (fixed: one quotient bit per cycle)

Ports:
clock  input  1  clock
reset  input  1  reset, synchronous, active-high
operand1  input  32  rs value (multiplicand/dividend; MTHI/MTLO source)
operand2  input  32  rt value (multiplier/divisor)
operation  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as NONE
start  input  1  request; sampled only when busy=0
busy  output  1  registered; high while a mul/div is in flight
dataRead  output  32  HI when operation=MFHI, LO when operation=MFLO, else 0
hi  output  32  current HI (debug/trace)
lo  output  32  current LO (debug/trace)

Behaviour:
- Reset (sync): HI=LO=0, busy=0, counter=0, FSM to IDLE. Any in-flight op is aborted and its result discarded.
- FSM states: IDLE, MUL, DIV.
- IDLE:
  - start with MULT/MULTU -> MUL. Latch operands and signedness; load counter with MUL_CYCLES.
  - start with DIV/DIVU -> DIV. Latch absolute values, quotient/remainder sign flags and a divide-by-zero flag; load counter with DIV_CYCLES.
  - start with MTHI/MTLO -> HI (resp. LO) <= operand1 at this edge. Stay IDLE; busy stays 0.
  - start with MFHI/MFLO/NONE -> no state change.
- Accepted at edge N:
  - busy=1 in cycles N+1 .. N+L (L = MUL_CYCLES or DIV_CYCLES).
  - HI/LO written at edge N+L; FSM returns to IDLE and busy=0 at that same edge.
  - MFLO presented in cycle N+L+1 reads the new value.
- MUL: 64-bit product of latched operands, signed for MULT, unsigned for MULTU. HI = product[63:32], LO = product[31:0]. The product may be formed in any way that meets timing; only the latency is fixed.
- DIV: restoring divide on magnitudes, one quotient bit per cycle, MSB first.
  - Final edge applies sign fixup: quotient negative iff operand signs differ (DIV only); remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
  - Overflow case DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: full DIV_CYCLES busy, then HI and LO left unchanged.
- start while busy=1: ignored, no side effects (protocol violation by the initiator).
- Operands changing during busy: no effect; all computation uses latched values.
- dataRead is purely combinational from operation and HI/LO, independent of start and busy. While busy=1 it returns the old HI/LO; EX is responsible for stalling.
- busy is a flop output only, so there is no start->busy combinational path.
- Reset asserted mid-MUL/DIV: at that edge busy=0, HI=LO=0, and the result never lands.

Test Plan:
- MULT 0xFFFFFFFE (-2) x 3, start 1 cycle -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MFLO returns 0xFFFFFFFA.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7 / 2 -> busy 32 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 7 / 2 -> LO=3, HI=1. DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- Preload HI=0x11 via MTHI and LO=0x22 via MTLO, then DIVU 5 / 0 -> busy 32 cycles; afterwards HI=0x11, LO=0x22. MFHI in the cycle right after MTHI returns 0x11, with busy never asserted.
- During MULT busy, pulse start with DIV 9/3 and change operands -> ignored; final HI/LO equal the MULT result, and busy falls after exactly MUL_CYCLES.
- Start DIVU 100/7, assert reset in busy cycle 10 -> next cycle busy=0, HI=LO=0; a new MULTU 2x3 then completes normally with LO=6.
